// File: rtl/ysyx_rnu_freelist_if.sv
// Free-list port bundle between the rename unit (master) and the
// physical-register free list (slave). The default widths fall back to
// 6/5 when the core-wide length macros are not defined.
`ifndef YSYX_PHY_LEN
`define YSYX_PHY_LEN 6
`endif
`ifndef YSYX_REG_LEN
`define YSYX_REG_LEN 5
`endif

interface rnu_fl_if #(
  parameter int PLEN = `YSYX_PHY_LEN,
  parameter int RLEN = `YSYX_REG_LEN
);
  logic            flush_pipe;
  logic [RLEN-1:0] flush_rd;
  logic            alloc_req;
  logic [PLEN-1:0] alloc_pr;
  logic            alloc_empty;
  logic            dealloc_req;
  logic [PLEN-1:0] dealloc_pr;

  modport master (
    output flush_pipe, flush_rd, alloc_req, dealloc_req, dealloc_pr,
    input  alloc_pr, alloc_empty
  );

  modport slave (
    input  flush_pipe, flush_rd, alloc_req, dealloc_req, dealloc_pr,
    output alloc_pr, alloc_empty
  );
endinterface

// File: rtl/ysyx_rnu_freelist.sv
// Physical-register free list: circular FIFO of unallocated PR numbers.
// Rename pops at the speculative head, commit pushes freed PRs at the tail
// and advances the committed head; a flush snaps head back to the committed
// head in one cycle.
// Optional macro YSYX_RNU_FL_CHECK_EN adds a simulation-only in-list bitmap
// with $fatal checks for double free, bad alloc, push-while-full and
// committed head overtaking the speculative head.
module ysyx_rnu_freelist #(
  parameter int PLEN = `YSYX_PHY_LEN,
  parameter int RLEN = `YSYX_REG_LEN
) (
  input logic     clock,
  input logic     reset,
  rnu_fl_if.slave fl
);
  localparam int DEPTH = 2**PLEN - 2**RLEN;
  localparam int IW    = $clog2(DEPTH);
  localparam int PW    = IW + 1;

  typedef logic [PW-1:0] ptr_t;

  // Index wraps explicitly at DEPTH-1 so non-power-of-two depths work;
  // the top bit toggles on every wrap to tell full from empty.
  function automatic ptr_t ptr_inc(input ptr_t p);
    if (p[IW-1:0] == IW'(DEPTH-1)) return {~p[IW], {IW{1'b0}}};
    else                           return p + PW'(1);
  endfunction

  logic [PLEN-1:0] fifo_q [DEPTH];
  ptr_t head_q, head_d;
  ptr_t cmt_q,  cmt_d;
  ptr_t tail_q, tail_d;
  logic alloc_fire, dealloc_fire, empty, full;

  // flush_rd belongs to the map-table side of the interface
  logic unused_flush_rd;
  assign unused_flush_rd = ^fl.flush_rd;

  assign empty        = (tail_q == head_q);
  assign full         = (tail_q == {~head_q[IW], head_q[IW-1:0]});
  assign alloc_fire   = fl.alloc_req && !empty && !fl.flush_pipe;
  assign dealloc_fire = fl.dealloc_req && (fl.dealloc_pr != '0);

  assign fl.alloc_pr    = fifo_q[head_q[IW-1:0]];
  assign fl.alloc_empty = empty;

  // Next pointers; flush takes the committed head including this cycle's push
  always_comb begin
    tail_d = tail_q;
    cmt_d  = cmt_q;
    head_d = head_q;
    if (dealloc_fire) begin
      tail_d = ptr_inc(tail_q);
      cmt_d  = ptr_inc(cmt_q);
    end
    if (fl.flush_pipe)   head_d = cmt_d;
    else if (alloc_fire) head_d = ptr_inc(head_q);
  end

  // Pointer and storage update; reset reloads the full list of unmapped PRs
  always_ff @(posedge clock) begin
    if (reset) begin
      head_q <= '0;
      cmt_q  <= '0;
      tail_q <= {1'b1, {IW{1'b0}}};
      for (int i = 0; i < DEPTH; i++) fifo_q[i] <= PLEN'(2**RLEN + i);
    end else begin
      head_q <= head_d;
      cmt_q  <= cmt_d;
      tail_q <= tail_d;
      if (dealloc_fire) fifo_q[tail_q[IW-1:0]] <= fl.dealloc_pr;
    end
  end

`ifdef YSYX_RNU_FL_CHECK_EN
  // Distance b->a in slots, negative or above DEPTH when b has passed a
  function automatic int ptr_dist(input ptr_t a, input ptr_t b);
    if (a[IW] == b[IW]) return int'(a[IW-1:0]) - int'(b[IW-1:0]);
    else                return int'(a[IW-1:0]) + DEPTH - int'(b[IW-1:0]);
  endfunction

  logic [2**PLEN-1:0] inlist_q;

  // In-list bitmap: cleared on pop, set on push, and re-set for the
  // speculative window a flush hands back to the list
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int p = 0; p < 2**PLEN; p++) inlist_q[p] <= (p >= 2**RLEN);
    end else begin
      if (alloc_fire) begin
        if (!inlist_q[fl.alloc_pr]) $fatal(1, "freelist: alloc of PR %0d not free", fl.alloc_pr);
        inlist_q[fl.alloc_pr] <= 1'b0;
      end
      if (fl.flush_pipe) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (((i - int'(cmt_d[IW-1:0]) + DEPTH) % DEPTH) < ptr_dist(head_q, cmt_d))
            inlist_q[fifo_q[i]] <= 1'b1;
        end
      end
      if (dealloc_fire) begin
        if (inlist_q[fl.dealloc_pr]) $fatal(1, "freelist: dealloc of free PR %0d", fl.dealloc_pr);
        if (full) $fatal(1, "freelist: dealloc while full");
        inlist_q[fl.dealloc_pr] <= 1'b1;
      end
      if (ptr_dist(head_d, cmt_d) < 0 || ptr_dist(head_d, cmt_d) > DEPTH)
        $fatal(1, "freelist: committed head overtook head");
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_rnu_freelist.sv
// Free-list bench: directed scenarios plus random traffic, checked every
// cycle against an unbounded-counter queue model of the list.
module tb_ysyx_rnu_freelist;
  localparam int PLEN = 6;
  localparam int RLEN = 5;
  localparam int D    = 2**PLEN - 2**RLEN;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  rnu_fl_if #(.PLEN(PLEN), .RLEN(RLEN)) fl ();

  ysyx_rnu_freelist #(.PLEN(PLEN), .RLEN(RLEN)) dut (
    .clock (clock),
    .reset (reset),
    .fl    (fl)
  );

  int errs   = 0;
  int checks = 0;

  // Model: free-running counters, slot = counter % D
  logic [PLEN-1:0] mem [D];
  int unsigned mh, mc, mt;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mh = 0; mc = 0; mt = D;
    for (int i = 0; i < D; i++) mem[i] = PLEN'(2**RLEN + i);
  endtask

  task automatic idle_inputs();
    fl.flush_pipe  = 1'b0;
    fl.flush_rd    = '0;
    fl.alloc_req   = 1'b0;
    fl.dealloc_req = 1'b0;
    fl.dealloc_pr  = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    model_reset();
  endtask

  // Compare outputs to the model, apply one cycle of inputs, advance the model
  task automatic step(input bit a, input bit d, input logic [PLEN-1:0] p, input bit f);
    bit  m_empty, afire, dfire;
    m_empty = (mt == mh);
    chk("alloc_empty", int'(fl.alloc_empty), int'(m_empty));
    chk("alloc_pr", int'(fl.alloc_pr), int'(mem[mh % D]));
    fl.alloc_req   = a;
    fl.dealloc_req = d;
    fl.dealloc_pr  = p;
    fl.flush_pipe  = f;
    fl.flush_rd    = RLEN'($urandom);
    afire = a && !m_empty && !f;
    dfire = d && (p != 0);
    if (dfire) begin
      mem[mt % D] = p;
      mt++; mc++;
    end
    if (f)          mh = mc;
    else if (afire) mh++;
    @(posedge clock); #1;
    idle_inputs();
  endtask

  // A nonzero PR that is not currently in the list
  function automatic logic [PLEN-1:0] pick();
    logic [PLEN-1:0] cand[$];
    for (int p = 1; p < 2**PLEN; p++) begin
      bit inl = 0;
      for (int unsigned k = mh; k < mt; k++) if (mem[k % D] == PLEN'(p)) inl = 1;
      if (!inl) cand.push_back(PLEN'(p));
    end
    return cand[$urandom_range(0, cand.size() - 1)];
  endfunction

  initial begin
    idle_inputs();
    model_reset();
    do_reset();
    chk("rst_pr", int'(fl.alloc_pr), 32);
    chk("rst_empty", int'(fl.alloc_empty), 0);

    // drain all 32 in order
    for (int i = 0; i < D; i++) begin
      chk("pop_seq", int'(fl.alloc_pr), 32 + i);
      step(1, 0, 0, 0);
    end
    chk("empty_after_32", int'(fl.alloc_empty), 1);
    step(1, 0, 0, 0);
    chk("empty_33rd", int'(fl.alloc_empty), 1);
    chk("pr_33rd", int'(fl.alloc_pr), 32);

    // p0 push is ignored: list stays empty
    step(0, 1, 0, 0);
    chk("p0_ignored", int'(fl.alloc_empty), 1);

    // alloc refused while empty, pushed 5 visible next cycle
    step(1, 1, 5, 0);
    chk("push_vis_empty", int'(fl.alloc_empty), 0);
    chk("push_vis_pr", int'(fl.alloc_pr), 5);
    step(1, 0, 0, 0);
    chk("pop5_empty", int'(fl.alloc_empty), 1);

    // mid-operation reset restores image
    do_reset();
    chk("rst2_pr", int'(fl.alloc_pr), 32);

    // alloc 4, commit 1, flush -> back to committed head (slot 1)
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
    step(0, 1, 7, 0);
    step(1, 0, 0, 1);
    chk("flush_pr", int'(fl.alloc_pr), 33);

    // flush with same-cycle dealloc at head=3, cmt=1 -> head=2
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
    step(0, 1, 7, 0);
    step(1, 1, 9, 1);
    chk("flush_dealloc_pr", int'(fl.alloc_pr), 34);
    for (int i = 0; i < 30; i++) step(1, 0, 0, 0);
    chk("pushed_7", int'(fl.alloc_pr), 7);
    step(1, 0, 0, 0);
    chk("tail_old_9", int'(fl.alloc_pr), 9);

    // steady state: pop and push every cycle, pointers wrap
    do_reset();
    for (int i = 0; i < 8; i++) step(1, 0, 0, 0);
    for (int i = 0; i < 100; i++) step(1, 1, pick(), 0);
    chk("steady_cnt", int'(mt - mh), 24);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      bit a, d, f;
      a = ($urandom_range(0, 3) != 0);
      d = ($urandom_range(0, 1) == 1) && (mh > mc);
      f = ($urandom_range(0, 15) == 0);
      step(a, d, d ? pick() : PLEN'($urandom_range(0, 1) ? 0 : 3), f);
    end
    step(0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
